// File: rtl/wb_scoreboard_arb_pkg.sv
// Shared definitions for the writeback scoreboard/arbiter: widths, register
// count and requester index encoding.
package wb_scoreboard_arb_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int RADDR_W   = 5;

  localparam int IDX_ALU = 0;
  localparam int IDX_MEM = 1;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_idx_e;

endpackage

// File: rtl/wb_scoreboard_arb_rr.sv
// Two-requester round-robin arbiter; the pointer only moves after a contested
// grant, so uncontested traffic never disturbs fairness.
//   state   | meaning
//   REQ_ALU | ALU wins the next contested cycle
//   REQ_MEM | MEM wins the next contested cycle
module wb_rr_arb
  import wb_scoreboard_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  req_idx_e ptr, ptr_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr <= REQ_ALU;
    else      ptr <= ptr_n;
  end

  always_comb begin
    gnt   = 2'b00;
    ptr_n = ptr;
    case (req)
      2'b01: gnt = 2'b01;
      2'b10: gnt = 2'b10;
      2'b11: begin
        if (ptr == REQ_MEM) begin
          gnt   = 2'b10;
          ptr_n = REQ_ALU;
        end else begin
          gnt   = 2'b01;
          ptr_n = REQ_MEM;
        end
      end
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/wb_scoreboard_arb.sv
// Register scoreboard with issue interlock, arbitrated ALU/load writeback and a
// registered regfile write port.
module wb_scoreboard_arb
  import wb_scoreboard_arb_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               iss_valid,
  input  logic [RADDR_W-1:0] iss_rs1,
  input  logic [RADDR_W-1:0] iss_rs2,
  input  logic [RADDR_W-1:0] iss_rd,
  output logic               iss_ready,
  input  logic               alu_valid,
  input  logic [RADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]    alu_data,
  output logic               alu_ready,
  input  logic               mem_valid,
  input  logic [RADDR_W-1:0] mem_rd,
  input  logic [XLEN-1:0]    mem_data,
  output logic               mem_ready,
  output logic               rf_we,
  output logic [RADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]    rf_wdata,
  output logic [NREGS-1:0]   busy,
  output logic               wb_err
);

  // Async assert, sync release: rst_i drops with rst and rises two edges later.
  logic [1:0] rst_sync;
  logic       rst_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync <= 2'b00;
    else      rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_i = rst_sync[1];

  logic [1:0] req, gnt;

  assign req = {mem_valid, alu_valid} & {2{rst_i}};

  wb_rr_arb u_arb (
    .clk (clk),
    .rst (rst_i),
    .req (req),
    .gnt (gnt)
  );

  assign alu_ready = gnt[IDX_ALU];
  assign mem_ready = gnt[IDX_MEM];

  logic               wb_acc;
  logic [RADDR_W-1:0] wb_rd;
  logic [XLEN-1:0]    wb_data;
  logic               wb_live;

  assign wb_acc  = |gnt;
  assign wb_rd   = gnt[IDX_MEM] ? mem_rd   : alu_rd;
  assign wb_data = gnt[IDX_MEM] ? mem_data : alu_data;
  assign wb_live = wb_acc && (wb_rd != '0);

  logic iss_fire;

  assign iss_ready = rst_i && !busy[iss_rs1] && !busy[iss_rs2] && !busy[iss_rd];
  assign iss_fire  = iss_valid && iss_ready;

  // Clear follows the registered commit; a set on the same edge overrides it.
  logic [NREGS-1:0] busy_n;

  always_comb begin
    busy_n = busy;
    if (rf_we) busy_n[rf_waddr] = 1'b0;
    if (iss_fire && (iss_rd != '0)) busy_n[iss_rd] = 1'b1;
    busy_n[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      busy     <= '0;
      wb_err   <= 1'b0;
    end else begin
      rf_we <= wb_live;
      if (wb_acc) begin
        rf_waddr <= wb_rd;
        rf_wdata <= wb_data;
      end
      if (wb_live && !busy[wb_rd]) wb_err <= 1'b1;
      busy <= busy_n;
    end
  end

endmodule

// File: tb/tb_wb_scoreboard_arb.sv
// Directed bench for wb_scoreboard_arb: expected grants and regfile writes are
// queued by the stimulus and consumed by an independent monitor.
module tb_wb_scoreboard_arb;

  logic        clk;
  logic        rst;
  logic        iss_valid;
  logic [4:0]  iss_rs1, iss_rs2, iss_rd;
  logic        iss_ready;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] busy;
  logic        wb_err;

  wb_scoreboard_arb dut (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid),
    .iss_rs1   (iss_rs1),
    .iss_rs2   (iss_rs2),
    .iss_rd    (iss_rd),
    .iss_ready (iss_ready),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .mem_valid (mem_valid),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .busy      (busy),
    .wb_err    (wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_wr[$];
  bit  exp_gnt[$];   // 0 = ALU, 1 = MEM
  int  tests = 0;
  int  fails = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [4:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_wr.push_back(w);
  endtask

  // Monitor: every visible grant and every regfile write must match the queues.
  initial begin
    forever begin
      @(negedge clk);
      if (alu_ready || mem_ready) begin
        if (alu_ready && mem_ready) check("double_grant", {alu_ready, mem_ready}, 2'b01);
        if (exp_gnt.size() == 0) check("unexpected_grant", {alu_ready, mem_ready}, 2'b00);
        else check("grant_order", {63'd0, mem_ready}, {63'd0, exp_gnt.pop_front()});
      end
      if (rf_we) begin
        if (exp_wr.size() == 0) check("unexpected_rf_we", {rf_waddr, rf_wdata}, 37'd0);
        else begin
          wr_t w;
          w = exp_wr.pop_front();
          check("rf_write", {rf_waddr, rf_wdata}, {w.addr, w.data});
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    iss_valid = 1'b0; iss_rs1 = '0; iss_rs2 = '0; iss_rd = '0;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = '0;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = '0;

    // Reset state with both requesters pushing
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_alu_ready", alu_ready, 0);
    check("rst_mem_ready", mem_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_rf", {rf_we, rf_waddr, rf_wdata}, 0);
    check("rst_wb_err", wb_err, 0);
    alu_valid = 1'b0; mem_valid = 1'b0;
    step();
    rst = 1'b1;
    repeat (3) step();

    // RAW interlock on x5
    iss_rs1 = 5'd1; iss_rs2 = 5'd2; iss_rd = 5'd5; iss_valid = 1'b1;
    #1 check("iss_ready_free", iss_ready, 1);
    step();
    iss_valid = 1'b0;
    #1 check("busy5_set", busy[5], 1);
    iss_rs1 = 5'd5; iss_rd = 5'd6;
    #1 check("iss_ready_raw", iss_ready, 0);
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234_5678;
    exp_gnt.push_back(1'b0); push_wr(5'd5, 32'h1234_5678);
    step();
    alu_valid = 1'b0;
    @(negedge clk);
    check("iss_ready_commit_cycle", iss_ready, 0);
    step();
    #1 check("iss_ready_after_commit", iss_ready, 1);
    check("busy5_clear", busy[5], 0);
    iss_rs1 = '0; iss_rs2 = '0; iss_rd = '0;

    // Claim x3, x4, x8, x9, then three contested cycles plus one single
    iss_valid = 1'b1;
    iss_rd = 5'd3; step();
    iss_rd = 5'd4; step();
    iss_rd = 5'd8; step();
    iss_rd = 5'd9; step();
    iss_valid = 1'b0; iss_rd = '0;
    #1 check("busy_claims", busy, 32'h0000_0318);

    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hAAAA_0000;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h5555_FFFF;
    exp_gnt.push_back(1'b0); push_wr(5'd3, 32'hAAAA_0000);
    step();
    alu_rd = 5'd8; alu_data = 32'h0000_0888;
    exp_gnt.push_back(1'b1); push_wr(5'd4, 32'h5555_FFFF);
    step();
    mem_rd = 5'd9; mem_data = 32'h9999_0009;
    exp_gnt.push_back(1'b0); push_wr(5'd8, 32'h0000_0888);
    step();
    alu_valid = 1'b0;
    exp_gnt.push_back(1'b1); push_wr(5'd9, 32'h9999_0009);
    step();
    mem_valid = 1'b0;
    repeat (2) step();
    check("busy_drained", busy, 0);
    check("wb_err_clean", wb_err, 0);

    // rd==0 writeback is accepted but never committed
    iss_valid = 1'b1; iss_rd = 5'd12; step();
    iss_valid = 1'b0; iss_rd = '0;
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hDEAD_BEEF;
    exp_gnt.push_back(1'b1);
    #1 check("x0_mem_ready", mem_ready, 1);
    step();
    mem_valid = 1'b0;
    @(negedge clk);
    check("x0_no_rf_we", rf_we, 0);
    check("x0_busy_unchanged", busy, 32'h0000_1000);
    check("x0_wb_err", wb_err, 0);

    // Writeback to a register nobody claimed
    step();
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h7777_0007;
    exp_gnt.push_back(1'b0); push_wr(5'd7, 32'h7777_0007);
    step();
    alu_valid = 1'b0;
    step();
    #1 check("wb_err_set", wb_err, 1);
    repeat (3) step();
    check("wb_err_sticky", wb_err, 1);

    // Reset while a write is registered; pointer currently favours MEM
    iss_valid = 1'b1; iss_rd = 5'd10; step();
    iss_valid = 1'b0; iss_rd = '0;
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hA0A0_0010;
    exp_gnt.push_back(1'b0);
    step();
    alu_valid = 1'b0;
    rst = 1'b0;
    #1 check("midrst_rf_we", rf_we, 0);
    check("midrst_busy", busy, 0);
    check("midrst_wb_err", wb_err, 0);
    step();
    rst = 1'b1;
    repeat (3) step();
    check("postrst_busy", busy, 0);
    check("postrst_rf_we", rf_we, 0);

    iss_valid = 1'b1;
    iss_rd = 5'd11; step();
    iss_rd = 5'd12; step();
    iss_valid = 1'b0; iss_rd = '0;
    alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 32'h1111_0011;
    mem_valid = 1'b1; mem_rd = 5'd12; mem_data = 32'h2222_0012;
    exp_gnt.push_back(1'b0); push_wr(5'd11, 32'h1111_0011);
    step();
    alu_valid = 1'b0;
    exp_gnt.push_back(1'b1); push_wr(5'd12, 32'h2222_0012);
    step();
    mem_valid = 1'b0;
    repeat (3) step();
    check("postrst_busy_drained", busy, 0);
    check("postrst_wb_err", wb_err, 0);

    check("gnt_queue_empty", exp_gnt.size(), 0);
    check("wr_queue_empty", exp_wr.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
